// File: rtl/hc02_tb_pkg.sv
// Shared types and helpers for the HC02 quad-NOR vector tester.
package hc02_tb_pkg;

  localparam int VEC_COUNT = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_e;

  // Expected device response for one stimulus vector.
  function automatic logic [3:0] nor4(input logic [3:0] a, input logic [3:0] b);
    return ~(a | b);
  endfunction

endpackage

// File: rtl/hc02_vector_tester_sync2.sv
// Two-flop synchroniser bringing the device's Y response into the clk domain.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/hc02_vector_tester.sv
// Exhaustive 256-vector stimulus/check engine for a quad 2-input NOR device.
// Optional build macro HC02_STOP_ON_FAIL_EN: halt and freeze A/B on the first mismatch.
module hc02_vector_tester
  import hc02_tb_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       a_out,
  output logic [3:0]       b_out,
  input  logic [3:0]       y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       fail_vec
);

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       IDX_LAST    = 8'(VEC_COUNT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  state_e           r_state;
  logic [7:0]       r_idx;
  logic [7:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [7:0]       r_fail_vec;
  logic             r_first_seen;

  logic [3:0] w_y_s;
  logic       w_mismatch;
  logic       w_stop;
  logic       w_hold;

  sync2 #(.W(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (y_in),
    .q     (w_y_s)
  );

  assign w_mismatch = (w_y_s != nor4(r_idx[3:0], r_idx[7:4]));

`ifdef HC02_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
  assign w_hold = r_first_seen;
`else
  assign w_stop = 1'b0;
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_fail_vec   <= '0;
      r_first_seen <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx        <= '0;
            r_cnt        <= '0;
            r_err        <= '0;
            r_fail_vec   <= '0;
            r_first_seen <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= DRIVE;
          end
        end
        DRIVE: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == SETTLE_LAST) r_state <= CHECK;
        end
        CHECK: begin
          if (w_mismatch) begin
            if (r_err != ERR_MAX) r_err <= r_err + 1'b1;
            // The sticky flag, not fail_vec==0, marks that a failure was captured.
            if (!r_first_seen) begin
              r_first_seen <= 1'b1;
              r_fail_vec   <= r_idx;
            end
          end
          if (w_stop || r_idx == IDX_LAST) begin
            r_state <= FIN;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_cnt   <= '0;
            r_state <= DRIVE;
          end
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (r_err == '0);
          r_idx   <= w_hold ? r_idx : 8'd0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a_out    = r_idx[3:0];
  assign b_out    = r_idx[7:4];
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_cnt  = r_err;
  assign fail_vec = r_fail_vec;

endmodule
